pipe_issue_ctrl: RTL and testbench

PIPE_ISSUE_CTRL -- requirements
Module: pipe_issue_ctrl

---
 rtl/pipe_issue_ctrl.sv | 108 ++++++++++
 tb/tb_pipe_issue_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_issue_ctrl.sv
// pipe_issue_ctrl
// Register scoreboard and issue control for the decode -> execute boundary.
// Each architectural register r1..r31 has a 3-bit countdown.
// The countdown is loaded with WB_LAT when an instruction that writes the
// register issues. The register is pending while its countdown is nonzero.
// A decode instruction that reads a pending register stalls. Otherwise it
// issues in the same cycle it is presented.
//
// Parameters
//   WB_LAT  cycles from issue until the written register is readable (1..7)
//   CNT_W   width of the saturating performance counters
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   id_valid          decode stage holds an instruction
//   id_op             decoded opcode, 2'b11 = no register write
//   id_rs1, id_rs2    source register indices
//   id_rd             destination register index
//   flush             discard the decode-stage instruction this cycle
//   stall             hold fetch/decode (combinational)
//   id_accept         decode instruction issues this cycle (combinational)
//   ex_valid/op/rd    registered issue slot to the execute stage
//   pending           bit n set while register n has an outstanding write
//   issue_cnt         saturating count of issued instructions
//   stall_cnt         saturating count of stall cycles
module pipe_issue_ctrl #(
  parameter int WB_LAT = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [1:0]       id_op,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             flush,
  output logic             stall,
  output logic             id_accept,
  output logic             ex_valid,
  output logic [1:0]       ex_op,
  output logic [4:0]       ex_rd,
  output logic [31:0]      pending,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [2:0] LAT = 3'(WB_LAT);

  // Countdown per register; r0 has none and is never pending.
  logic [2:0] wb_cnt [1:31];
  logic       hazard;
  logic       writes_rd;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    pending = '0;
    for (int n = 1; n < 32; n++) begin
      pending[n] = (wb_cnt[n] != 3'd0);
    end
  end

  // The hazard uses the pre-issue scoreboard only. This covers a source
  // that names the instruction's own destination, and a counter at 1
  // that is in its final cycle.
  assign hazard    = id_valid && (pending[id_rs1] || pending[id_rs2]);
  assign stall     = !rst && hazard && !flush;
  assign id_accept = !rst && id_valid && !hazard && !flush;
  assign writes_rd = id_accept && (id_op != 2'b11) && (id_rd != 5'd0);

  // Decode/issue -> execute slot and scoreboard update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 1; n < 32; n++) begin
        wb_cnt[n] <= 3'd0;
      end
      ex_valid  <= 1'b0;
      ex_op     <= 2'b00;
      ex_rd     <= 5'd0;
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int n = 1; n < 32; n++) begin
        // A load takes priority over the decrement, so a WAW write
        // restarts the countdown at WB_LAT.
        if (writes_rd && (id_rd == 5'(n))) begin
          wb_cnt[n] <= LAT;
        end else if (wb_cnt[n] != 3'd0) begin
          wb_cnt[n] <= wb_cnt[n] - 3'd1;
        end
      end
      ex_valid <= id_accept;
      if (id_accept) begin
        ex_op <= id_op;
        ex_rd <= id_rd;
      end
      if (id_accept) begin
        issue_cnt <= sat_inc(issue_cnt);
      end
      if (stall) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Testbench for pipe_issue_ctrl.
// The reference model records, for each register, the first cycle in which
// the register becomes readable. A register is pending while the current
// cycle is earlier than that cycle. Directed scenarios run first, then
// randomized traffic. CNT_W is reduced so that counter saturation is
// reached quickly.
module tb_pipe_issue_ctrl;

  localparam int W    = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid = 1'b0;
  logic [1:0]    id_op = 2'b00;
  logic [4:0]    id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic          flush = 1'b0;
  logic          stall, id_accept, ex_valid;
  logic [1:0]    ex_op;
  logic [4:0]    ex_rd;
  logic [31:0]   pending;
  logic [CW-1:0] issue_cnt, stall_cnt;

  pipe_issue_ctrl #(.WB_LAT(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
    .stall(stall), .id_accept(id_accept), .ex_valid(ex_valid),
    .ex_op(ex_op), .ex_rd(ex_rd), .pending(pending),
    .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int ready [32];
  int e_issue = 0, e_stall = 0;
  logic       e_exv = 1'b0;
  logic [1:0] e_op  = 2'b00;
  logic [4:0] e_rd  = 5'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] m_pending();
    logic [31:0] p;
    p = '0;
    for (int n = 1; n < 32; n++) p[n] = (cyc < ready[n]);
    return p;
  endfunction

  task automatic step(input logic v, input logic [1:0] op, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [4:0] rd,
                      input logic fl, input logic r);
    logic [31:0] mp;
    logic hz, e_acc, e_st;
    @(negedge clk);
    id_valid = v; id_op = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    flush = fl; rst = r;
    #1;
    mp    = m_pending();
    hz    = v && (mp[r1] || mp[r2]);
    e_acc = !r && v && !hz && !fl;
    e_st  = !r && hz && !fl;
    chk("stall", {31'd0, stall}, {31'd0, e_st});
    chk("accept", {31'd0, id_accept}, {31'd0, e_acc});
    @(posedge clk);
    #1;
    if (r) begin
      for (int n = 0; n < 32; n++) ready[n] = 0;
      e_exv = 1'b0; e_op = 2'b00; e_rd = 5'd0; e_issue = 0; e_stall = 0;
    end else begin
      if (e_acc && op != 2'b11 && rd != 5'd0) ready[rd] = cyc + 1 + W;
      e_exv = e_acc;
      if (e_acc) begin
        e_op = op; e_rd = rd;
        if (e_issue < CMAX) e_issue++;
      end
      if (e_st && e_stall < CMAX) e_stall++;
    end
    cyc++;
    chk("pending", pending, m_pending());
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, e_exv});
    chk("ex_op", {30'd0, ex_op}, 32'(e_op));
    chk("ex_rd", {27'd0, ex_rd}, 32'(e_rd));
    chk("issue_cnt", 32'(issue_cnt), 32'(e_issue));
    chk("stall_cnt", 32'(stall_cnt), 32'(e_stall));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    step(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
  endtask

  initial begin
    for (int n = 0; n < 32; n++) ready[n] = 0;
    do_reset();
    chk("rst_pending", pending, 32'd0);
    chk("rst_issue", 32'(issue_cnt), 32'd0);

    // Independent back-to-back issue
    step(1'b1, 2'b00, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    step(1'b1, 2'b00, 5'd5, 5'd6, 5'd4, 1'b0, 1'b0);
    chk("indep_issue_cnt", 32'(issue_cnt), 32'd2);
    chk("indep_stall_cnt", 32'(stall_cnt), 32'd0);
    idle(4);

    // RAW: reader of r3 stalls W cycles, then issues
    do_reset();
    step(1'b1, 2'b00, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) begin
      step(1'b1, 2'b01, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0);
    end
    step(1'b1, 2'b01, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0);
    chk("raw_stall_cnt", 32'(stall_cnt), 32'd3);
    chk("raw_issue_cnt", 32'(issue_cnt), 32'd2);
    idle(4);

    // Non-writing op and rd=0 never create a hazard
    do_reset();
    step(1'b1, 2'b11, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    chk("nowrite_pending", pending, 32'd0);
    step(1'b1, 2'b00, 5'd3, 5'd3, 5'd6, 1'b0, 1'b0);
    step(1'b1, 2'b00, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0);
    chk("rd0_stall_cnt", 32'(stall_cnt), 32'd0);
    idle(4);

    // WAW reload: reader of r5 waits for the second write
    do_reset();
    step(1'b1, 2'b00, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
    step(1'b1, 2'b00, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
    for (int i = 0; i < W + 1; i++) step(1'b1, 2'b10, 5'd5, 5'd0, 5'd8, 1'b0, 1'b0);
    chk("waw_stall_cnt", 32'(stall_cnt), 32'(W));
    chk("waw_pending", pending, 32'h0000_0100);
    idle(4);

    // Self-reference: rs == rd judged only against the old scoreboard
    do_reset();
    step(1'b1, 2'b00, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0);
    chk("self_ref_stall", 32'(stall_cnt), 32'd0);
    idle(4);

    // Flush during a RAW stall
    do_reset();
    step(1'b1, 2'b00, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    step(1'b1, 2'b01, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0);
    step(1'b1, 2'b01, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0);
    chk("flush_stall_cnt", 32'(stall_cnt), 32'd1);
    step(1'b1, 2'b01, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0);
    step(1'b1, 2'b01, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0);
    chk("flush_issue_cnt", 32'(issue_cnt), 32'd2);
    idle(4);

    // Reset in the middle of a stall
    do_reset();
    step(1'b1, 2'b00, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    step(1'b1, 2'b01, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0);
    step(1'b1, 2'b01, 5'd3, 5'd1, 5'd2, 1'b0, 1'b1);
    chk("midrst_pending", pending, 32'd0);
    step(1'b1, 2'b01, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0);
    chk("midrst_ex_valid", {31'd0, ex_valid}, 32'd1);
    idle(4);

    // Saturation of the issue counter
    do_reset();
    for (int i = 0; i < CMAX + 4; i++) step(1'b1, 2'b11, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk("sat_issue_cnt", 32'(issue_cnt), 32'(CMAX));

    // Randomized traffic over a small register window to provoke hazards
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 59) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
